lsu: RTL and testbench

Load/store unit for the MEM stage of the RISC-V pipeline. It sits between the EX/MEM pipeline register and `DataMem` and converts RV32I load and store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed `DataMem` accesses. Sub-word stores are implemented as a two-cycle read-modify-write. Load data is aligned, extended and registered before it goes to writeback.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_if.sv | 37 +++
 rtl/lsu_load_align.sv | 32 +++
 rtl/lsu.sv | 120 ++++++++++++
 tb/tb_lsu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : funct3 encodings, FSM state type and misalignment check for lsu.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_e;

    // funct3[1:0] is the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Request/response and DataMem bus bundle of the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        output mem_read_en, mem_write_en, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        input  mem_read_en, mem_write_en, mem_addr, mem_write_data
    );

endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Selects the byte/half/word lane of a load and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    import lsu_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LW:      o_data = i_word;
            LBU:     o_data = {24'd0, w_byte};
            LHU:     o_data = {16'd0, w_half};
            default: o_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : RV32I load/store unit; sub-word stores are two-cycle RMW.
//            Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    import lsu_pkg::*;

    lsu_state_e  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [15:0] r_wdata;
    logic [31:0] r_word;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_misaligned;

    logic        w_accept;
    logic        w_load_ok;
    logic        w_store_ok;
    logic        w_mis;
    logic        w_do_load;
    logic        w_do_sw;
    logic        w_do_rmw;
    logic        w_in_rmw;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_load_ok  = !bus.req_we && (bus.req_funct3 == LB  || bus.req_funct3 == LH ||
                                     bus.req_funct3 == LW  || bus.req_funct3 == LBU ||
                                     bus.req_funct3 == LHU);
        w_store_ok = bus.req_we  && (bus.req_funct3 == SB  || bus.req_funct3 == SH ||
                                     bus.req_funct3 == SW);
`ifdef LSU_MISALIGN_TRAP_EN
        w_mis = (w_load_ok || w_store_ok) && is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
        w_mis = 1'b0;
`endif
        w_do_load = w_accept && w_load_ok && !w_mis;
        w_do_sw   = w_accept && w_store_ok && (bus.req_funct3 == SW) && !w_mis;
        w_do_rmw  = w_accept && w_store_ok && (bus.req_funct3 != SW) && !w_mis;
    end

    // rst gates the RMW write combinationally so it dies the instant reset rises.
    assign w_in_rmw = (r_state == RMW_WR) && !rst;

    always_comb begin
        w_merge = r_word;
        if (r_funct3 == SH)
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        else
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end

    assign bus.mem_read_en    = w_do_load || w_do_rmw;
    assign bus.mem_write_en   = w_do_sw || w_in_rmw;
    assign bus.mem_addr       = (r_state == RMW_WR) ? {2'b00, r_addr[31:2]}
                                                    : {2'b00, bus.req_addr[31:2]};
    assign bus.mem_write_data = (r_state == RMW_WR) ? w_merge : bus.req_wdata;

    lsu_load_align u_align (
        .i_word    (bus.mem_read_data),
        .i_addr_lo (bus.req_addr[1:0]),
        .i_funct3  (bus.req_funct3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_addr           <= 32'd0;
            r_funct3         <= 3'd0;
            r_wdata          <= 16'd0;
            r_word           <= 32'd0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= 32'd0;
            r_rsp_misaligned <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_do_rmw) begin
                        r_state  <= RMW_WR;
                        r_addr   <= bus.req_addr;
                        r_funct3 <= bus.req_funct3;
                        r_wdata  <= bus.req_wdata[15:0];
                        r_word   <= bus.mem_read_data;
                    end else if (w_accept) begin
                        r_rsp_valid      <= 1'b1;
                        r_rsp_rdata      <= w_do_load ? w_load_data : 32'd0;
                        r_rsp_misaligned <= w_mis;
                    end
                end
                RMW_WR: begin
                    r_state          <= IDLE;
                    r_rsp_valid      <= 1'b1;
                    r_rsp_rdata      <= 32'd0;
                    r_rsp_misaligned <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.rsp_misaligned = r_rsp_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Directed plus random checks of lsu against a word-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        pre_we   = 1'b0;
    logic [3:0]  pre_idx  = 4'd0;
    logic [31:0] pre_data = 32'd0;

    assign bus.mem_read_data = mem[bus.mem_addr[3:0]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (bus.mem_write_en)
            mem[bus.mem_addr[3:0]] <= bus.mem_write_data;
    end

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] a,
                                              input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] m;
        if (f3 == 3'd0) begin
            m = 32'hFF << (8 * a);
            return (w & ~m) | ((d & 32'hFF) << (8 * a));
        end
        m = 32'hFFFF << (a[1] ? 16 : 0);
        return (w & ~m) | ((d & 32'hFFFF) << (a[1] ? 16 : 0));
    endfunction

    // One request, held until the next call changes it (models a stalled EX/MEM).
    task automatic req(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                       input logic [31:0] wd);
        logic        legal, mis, acc, rmw, exp_rd, exp_wr;
        logic [3:0]  idx;
        logic [31:0] exp_data, nw;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = {26'd0, addr};
        bus.req_wdata  = wd;
        idx    = addr[5:2];
        legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
        mis    = TRAP && legal && ((f3[1:0] == 2'd1 && addr[0]) ||
                                   (f3[1:0] == 2'd2 && addr[1:0] != 2'd0));
        acc    = legal && !mis;
        rmw    = acc && we && f3 != 3'd2;
        exp_rd = acc && (!we || rmw);
        exp_wr = acc && we && !rmw;
        exp_data = (acc && !we) ? ref_load(ref_mem[idx], addr[1:0], f3) : 32'd0;
        #1;
        chk("req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mem_read_en", {31'd0, bus.mem_read_en}, {31'd0, exp_rd});
        chk("mem_write_en", {31'd0, bus.mem_write_en}, {31'd0, exp_wr});
        if (exp_rd || exp_wr) chk("mem_addr", bus.mem_addr, {28'd0, idx});
        if (exp_wr) chk("sw_wdata", bus.mem_write_data, wd);
        @(posedge clk); #1;
        if (rmw) begin
            nw = ref_store(ref_mem[idx], addr[1:0], f3, wd);
            chk("rmw_ready_low", {31'd0, bus.req_ready}, 32'd0);
            chk("rmw_write_en", {31'd0, bus.mem_write_en}, 32'd1);
            chk("rmw_read_en", {31'd0, bus.mem_read_en}, 32'd0);
            chk("rmw_wdata", bus.mem_write_data, nw);
            chk("rmw_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            ref_mem[idx] = nw;
            @(posedge clk); #1;
        end else if (exp_wr) begin
            ref_mem[idx] = wd;
        end
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, exp_data);
        chk("rsp_misaligned", {31'd0, bus.rsp_misaligned}, {31'd0, mis});
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] w0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v = (i == 1) ? 32'h8000_F0A5 : (i == 2) ? 32'h0000_0008 : $urandom;
            pre_we   = 1'b1;
            pre_idx  = i[3:0];
            pre_data = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_mis", {31'd0, bus.rsp_misaligned}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_read_en", {31'd0, bus.mem_read_en}, 32'd0);
        chk("rst_write_en", {31'd0, bus.mem_write_en}, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;

        req(1'b0, 3'd0, 6'd4, 32'd0);
        chk("lb4_const", bus.rsp_rdata, 32'hFFFF_FFA5);
        req(1'b0, 3'd4, 6'd5, 32'd0);
        chk("lbu5_const", bus.rsp_rdata, 32'h0000_00F0);
        req(1'b0, 3'd1, 6'd6, 32'd0);
        chk("lh6_const", bus.rsp_rdata, 32'hFFFF_8000);
        req(1'b0, 3'd5, 6'd6, 32'd0);
        chk("lhu6_const", bus.rsp_rdata, 32'h0000_8000);
        req(1'b1, 3'd0, 6'd9, 32'h0000_0077);
        chk("sb9_const", mem[2], 32'h0000_7708);
        req(1'b1, 3'd2, 6'd12, 32'hDEAD_BEEF);
        req(1'b0, 3'd2, 6'd12, 32'd0);
        chk("lw12_const", bus.rsp_rdata, 32'hDEAD_BEEF);
        req(1'b0, 3'd2, 6'd2, 32'd0);
        chk("lw2_mis_const", {31'd0, bus.rsp_misaligned}, {31'd0, TRAP});
        req(1'b1, 3'd1, 6'd3, 32'h0000_1234);
        req(1'b0, 3'd3, 6'd8, 32'd0);
        req(1'b0, 3'd7, 6'd8, 32'd0);
        req(1'b1, 3'd5, 6'd8, 32'hFFFF_FFFF);
        req(1'b1, 3'd1, 6'd6, 32'hABCD_5A5A);
        idle();

        for (int n = 0; n < 300; n++) begin
            req(1'(($urandom % 2)), 3'($urandom % 8), 6'($urandom % 64), $urandom);
            if ($urandom % 4 == 0) idle();
        end
        idle();

        // Reset landing in the RMW write cycle must cancel the write.
        w0 = ref_mem[0];
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = ~w0;
        @(posedge clk); #1;
        chk("rmw_pre_rst_wr", {31'd0, bus.mem_write_en}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_rmw_wr_off", {31'd0, bus.mem_write_en}, 32'd0);
        chk("rst_rmw_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_word0_kept", mem[0], w0);
        req(1'b0, 3'd2, 6'd0, 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
